// File: rtl/pattern_ddr3_loader.sv
// Loads a header+body pattern stream into DDR3 from address 0, then sets the on-chip "loaded" flag.
// Up to 1 word/cycle; s_ready follows EMIF acceptance of the held write.
module pattern_ddr3_loader #(
  parameter logic [10:0]  FLAG_ADDR  = 11'd2,
  parameter logic [255:0] FLAG_VALUE = 256'h77,
  parameter logic [21:0]  MAX_WORDS  = 22'h3FFFFF
) (
  input  logic         ddr3_emif_clk,
  input  logic         ddr3_emif_rst_n,
  input  logic         start,
  input  logic         s_valid,
  input  logic [255:0] s_data,
  output logic         s_ready,
  input  logic         ddr3_emif_ready,
  output logic         ddr3_emif_write,
  output logic         ddr3_emif_read,
  output logic [21:0]  ddr3_emif_addr,
  output logic [255:0] ddr3_emif_write_data,
  output logic [31:0]  ddr3_emif_byte_enable,
  output logic [4:0]   ddr3_emif_burst_count,
  output logic         onchip_mem_clken,
  output logic         onchip_mem_chip_select,
  output logic         onchip_mem_write,
  output logic         onchip_mem_read,
  output logic [10:0]  onchip_mem_addr,
  output logic [31:0]  onchip_mem_byte_enable,
  output logic [255:0] onchip_mem_write_data,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [21:0]  words_written
);

  typedef enum logic [2:0] {IDLE, CLR_FLAG, HDR, CALC, BODY, FLAG} state_t;

  state_t        state, state_nxt;
  logic          wr_q;
  logic [21:0]   addr_q;
  logic [255:0]  data_q;
  logic          err_q;
  logic [21:0]   ww_q;
  logic [21:0]   total_q;
  logic [21:0]   in_cnt_q;

  logic [23:0]   wpp;
  logic [39:0]   total_calc;
  logic          calc_err;
  logic          emif_acc;
  logic          stream_acc;
  logic          last_acc;
  logic          mem_strobe;
  logic [255:0]  mem_data;

  // During CALC the header is still held in the write-data register, so size it from there.
  assign wpp        = data_q[191:168] + {23'd0, |data_q[167:160]};
  assign total_calc = {16'd0, wpp} * {24'd0, data_q[143:128]};
  assign calc_err   = (total_calc == 40'd0) || (total_calc > {18'd0, MAX_WORDS});

  assign emif_acc   = wr_q & ddr3_emif_ready;
  assign stream_acc = s_valid & s_ready;
  assign last_acc   = (state == BODY) && emif_acc && ((ww_q + 22'd1) == total_q);

  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    mem_strobe = 1'b0;
    mem_data   = 256'h0;
    done       = 1'b0;
    case (state)
      IDLE:     if (start) state_nxt = CLR_FLAG;
      CLR_FLAG: begin
        mem_strobe = 1'b1;
        state_nxt  = HDR;
      end
      HDR: begin
        s_ready = !wr_q || ddr3_emif_ready;
        if (stream_acc) state_nxt = CALC;
      end
      CALC: begin
        // Hold here until the header write is accepted so the EMIF is never left mid-command.
        if (!(wr_q && !ddr3_emif_ready)) state_nxt = calc_err ? IDLE : BODY;
      end
      BODY: begin
        s_ready = (in_cnt_q != total_q) && (!wr_q || ddr3_emif_ready);
        if (last_acc) state_nxt = FLAG;
      end
      FLAG: begin
        mem_strobe = 1'b1;
        mem_data   = FLAG_VALUE;
        done       = 1'b1;
        state_nxt  = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n) begin
    if (!ddr3_emif_rst_n) begin
      state    <= IDLE;
      wr_q     <= 1'b0;
      addr_q   <= 22'd0;
      data_q   <= 256'h0;
      err_q    <= 1'b0;
      ww_q     <= 22'd0;
      total_q  <= 22'd0;
      in_cnt_q <= 22'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        err_q <= 1'b0;
        ww_q  <= 22'd0;
      end
      if (stream_acc) begin
        wr_q   <= 1'b1;
        data_q <= s_data;
        addr_q <= (state == HDR) ? 22'd0 : addr_q + 22'd1;
      end else if (emif_acc) begin
        wr_q <= 1'b0;
      end
      if (state == BODY && emif_acc) ww_q <= ww_q + 22'd1;
      if (state == BODY && stream_acc) in_cnt_q <= in_cnt_q + 22'd1;
      if (state == CALC) begin
        total_q  <= total_calc[21:0];
        in_cnt_q <= 22'd0;
        if (state_nxt == IDLE) err_q <= 1'b1;
      end
    end
  end

  assign ddr3_emif_write        = wr_q;
  assign ddr3_emif_read         = 1'b0;
  assign ddr3_emif_addr         = addr_q;
  assign ddr3_emif_write_data   = data_q;
  assign ddr3_emif_byte_enable  = {32{wr_q}};
  assign ddr3_emif_burst_count  = 5'd1;
  assign onchip_mem_clken       = mem_strobe;
  assign onchip_mem_chip_select = mem_strobe;
  assign onchip_mem_write       = mem_strobe;
  assign onchip_mem_read        = 1'b0;
  assign onchip_mem_addr        = mem_strobe ? FLAG_ADDR : 11'd0;
  assign onchip_mem_byte_enable = {32{mem_strobe}};
  assign onchip_mem_write_data  = mem_data;
  assign busy                   = (state != IDLE);
  assign err                    = err_q;
  assign words_written          = ww_q;

endmodule

// File: tb/tb_pattern_ddr3_loader.sv
// Scoreboard bench for pattern_ddr3_loader: expected EMIF and on-chip writes are queued at stimulus time.
module tb_pattern_ddr3_loader;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         s_valid = 1'b0;
  logic [255:0] s_data = '0;
  logic         s_ready;
  logic         ready = 1'b1;
  logic         wr, rd;
  logic [21:0]  addr;
  logic [255:0] wdata;
  logic [31:0]  be;
  logic [4:0]   burst;
  logic         m_clken, m_cs, m_wr, m_rd;
  logic [10:0]  m_addr;
  logic [31:0]  m_be;
  logic [255:0] m_data;
  logic         busy, done, err;
  logic [21:0]  ww;

  pattern_ddr3_loader dut (
    .ddr3_emif_clk(clk), .ddr3_emif_rst_n(rst_n), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .ddr3_emif_ready(ready), .ddr3_emif_write(wr), .ddr3_emif_read(rd),
    .ddr3_emif_addr(addr), .ddr3_emif_write_data(wdata),
    .ddr3_emif_byte_enable(be), .ddr3_emif_burst_count(burst),
    .onchip_mem_clken(m_clken), .onchip_mem_chip_select(m_cs),
    .onchip_mem_write(m_wr), .onchip_mem_read(m_rd), .onchip_mem_addr(m_addr),
    .onchip_mem_byte_enable(m_be), .onchip_mem_write_data(m_data),
    .busy(busy), .done(done), .err(err), .words_written(ww)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [277:0] emq[$];
  logic [266:0] onq[$];
  logic [255:0] flag_mem = '0;
  bit  rnd_mode = 1'b0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  exp_last = 0;
  int  first_cyc = 0;
  int  last_cyc = 0;
  bit  prev_stall = 1'b0;
  bit  prev_last = 1'b0;
  logic [21:0]  prev_addr;
  logic [255:0] prev_data;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_hdr(input logic [31:0] tp, input logic [31:0] pn);
    return {32'd64, 32'd8, tp, pn, 32'd0, 32'd0, 32'd0, 32'h0};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops expected writes as the DUT commits them.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_last  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_wr", 256'(wr), 256'd1);
        check("hold_addr", 256'(addr), 256'(prev_addr));
        check("hold_data", wdata, prev_data);
      end
      if (prev_last || done) check("done_lat", 256'(done), 256'(prev_last));
      if (done) done_cnt++;
      prev_last = 1'b0;
      if (wr && ready) begin
        if (emq.size() == 0) check("emif_unexp", 256'(addr), 256'h3FFFFF);
        else begin
          logic [277:0] e;
          e = emq.pop_front();
          check("emif_addr", 256'(addr), 256'(e[277:256]));
          check("emif_data", wdata, e[255:0]);
          check("emif_be", 256'(be), 256'hFFFFFFFF);
        end
        if (addr == 22'd1) first_cyc = cyc;
        if (exp_last != 0 && int'(addr) == exp_last) begin
          last_cyc  = cyc;
          prev_last = 1'b1;
        end
      end
      if (m_wr && m_cs && m_clken) begin
        if (onq.size() == 0) check("mem_unexp", m_data, 256'h1);
        else begin
          logic [266:0] o;
          o = onq.pop_front();
          check("mem_addr", 256'(m_addr), 256'(o[266:256]));
          check("mem_data", m_data, o[255:0]);
          check("mem_be", 256'(m_be), 256'hFFFFFFFF);
        end
        if (m_addr == 11'd2) flag_mem = m_data;
      end
      prev_stall = wr && !ready;
      prev_addr  = addr;
      prev_data  = wdata;
    end
  end

  task automatic send_word(input logic [255:0] d);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    while (!s_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) check("s_ready_timeout", 256'd0, 256'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 2000) check("idle_timeout", 256'd0, 256'd1);
  endtask

  task automatic do_load(input logic [31:0] tp, input logic [31:0] pn, input int nbody,
                         input bit ok, input bit chk_tp, input int start_at);
    logic [255:0] h, d;
    done_cnt = 0;
    exp_last = ok ? nbody : 0;
    onq.push_back({11'd2, 256'h0});
    if (ok) onq.push_back({11'd2, 256'h77});
    pulse_start();
    check("clr_latency", 256'(m_wr), 256'd1);
    h = mk_hdr(tp, pn);
    emq.push_back({22'd0, h});
    send_word(h);
    for (int i = 0; i < nbody; i++) begin
      if (i == start_at) pulse_start();
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      emq.push_back({22'(i + 1), d});
      send_word(d);
    end
    wait_idle();
    check("done_cnt", 256'(done_cnt), ok ? 256'd1 : 256'd0);
    check("err", 256'(err), ok ? 256'd0 : 256'd1);
    check("words_written", 256'(ww), ok ? 256'(nbody) : 256'd0);
    check("flag", flag_mem, ok ? 256'h77 : 256'h0);
    check("emq_drained", 256'(emq.size()), 256'd0);
    check("onq_drained", 256'(onq.size()), 256'd0);
    if (chk_tp) check("body_gap", 256'(last_cyc - first_cyc), 256'(nbody - 1));
  endtask

  initial begin
    #2;
    check("rst_wr", 256'(wr), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_burst", 256'(burst), 256'd1);
    check("rst_s_ready", 256'(s_ready), 256'd0);
    check("rst_mem_wr", 256'(m_wr), 256'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    do_load(32'd512, 32'd2, 4, 1'b1, 1'b1, -1);
    do_load(32'd300, 32'd3, 6, 1'b1, 1'b1, -1);
    rnd_mode = 1'b1;
    do_load(32'd1024, 32'd3, 12, 1'b1, 1'b0, -1);
    rnd_mode = 1'b0;
    @(posedge clk);
    #1;

    do_load(32'd0, 32'd5, 0, 1'b0, 1'b0, -1);
    s_valid = 1'b1;
    @(negedge clk);
    check("idle_s_ready", 256'(s_ready), 256'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    do_load(32'h4000_0000, 32'd1, 0, 1'b0, 1'b0, -1);

    begin
      logic [255:0] d;
      int n;
      done_cnt = 0;
      exp_last = 4;
      onq.push_back({11'd2, 256'h0});
      onq.push_back({11'd2, 256'h77});
      pulse_start();
      emq.push_back({22'd0, mk_hdr(32'd512, 32'd2)});
      send_word(mk_hdr(32'd512, 32'd2));
      for (int i = 0; i < 2; i++) begin
        d = {8{$urandom}};
        emq.push_back({22'(i + 1), d});
        send_word(d);
      end
      n = 0;
      @(negedge clk);
      while (ww != 22'd2 && n < 100) begin
        n++;
        @(negedge clk);
      end
      check("mid_ww", 256'(ww), 256'd2);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_wr", 256'(wr), 256'd0);
      check("mid_rst_busy", 256'(busy), 256'd0);
      check("mid_rst_ww", 256'(ww), 256'd0);
      check("mid_rst_burst", 256'(burst), 256'd1);
      check("mid_rst_mem_wr", 256'(m_wr), 256'd0);
      check("mid_rst_flag_pending", 256'(onq.size()), 256'd1);
      check("mid_rst_flag", flag_mem, 256'h0);
      check("mid_rst_done", 256'(done_cnt), 256'd0);
      onq.delete();
      emq.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
    end

    rnd_mode = 1'b1;
    do_load(32'd256, 32'd4, 4, 1'b1, 1'b0, -1);
    rnd_mode = 1'b0;
    do_load(32'd512, 32'd3, 6, 1'b1, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
